wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered memory results onto the
// register file write port and tracks pending long-latency destinations.
module wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_AW-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_AW-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    input  logic                 iss_valid,
    input  logic [REG_AW-1:0]    iss_rd,
    output logic [2**REG_AW-1:0] busy_o,
    output logic                 stall_o,
    output logic                 wen,
    output logic [REG_AW-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int NREG  = 2**REG_AW;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_FIFO
    } sel_e;

    logic [REG_AW-1:0] q_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_n;

    logic              full;
    logic              enq;
    logic              deq;
    sel_e              sel;
    logic [REG_AW-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [REG_AW-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign full      = (count == FULL_CNT);
    assign stall_o   = rst & full;
    assign mem_ready = rst & ~full;
    assign alu_ready = rst & ~full;
    assign busy_o    = busy_q;

    assign head_rd   = q_rd[rptr];
    assign head_data = q_data[rptr];

    // Full FIFO outranks the ALU so memory results cannot starve.
    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            full:                                     sel = SEL_FIFO;
            !full && alu_valid:                       sel = SEL_ALU;
            !full && !alu_valid && (count != '0):     sel = SEL_FIFO;
            default:                                  sel = SEL_NONE;
        endcase
    end

    assign enq = mem_valid & mem_ready;
    assign deq = (sel == SEL_FIFO);

    always_comb begin
        sel_rd   = head_rd;
        sel_data = head_data;
        if (sel == SEL_ALU) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    always_comb begin
        count_n = count;
        unique case ({enq, deq})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // A same-edge issue must win over the clear from the draining head.
    always_comb begin
        busy_n = busy_q;
        if (deq) begin
            busy_n[head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_n[iss_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[wptr]   <= mem_rd;
            q_data[wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
            busy_q <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (deq) begin
                rptr <= rptr + PTR_W'(1);
            end
            count  <= count_n;
            busy_q <= busy_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wen     <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (sel != SEL_NONE) begin
            wen     <= (sel_rd != '0);
            rd_addr <= sel_rd;
            rd_data <= sel_data;
        end else begin
            wen     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU path, memory FIFO, scoreboard,
// rd=0 handling and reset while the FIFO holds entries.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        iss_valid;
    logic [2:0]  iss_rd;
    logic [7:0]  busy_o;
    logic        stall_o;
    logic        wen;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(
        .DATA_W(16),
        .REG_AW(3),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .iss_valid(iss_valid),
        .iss_rd(iss_rd),
        .busy_o(busy_o),
        .stall_o(stall_o),
        .wen(wen),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        #0;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic w,
                            input logic [2:0] a, input logic [15:0] d);
        check({tag, ".wen"}, 32'(wen), 32'(w));
        check({tag, ".addr"}, 32'(rd_addr), 32'(a));
        check({tag, ".data"}, 32'(rd_data), 32'(d));
    endtask

    initial begin
        rst       = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;

        tick();
        tick();
        check_wr("rst", 1'b0, 3'd0, 16'h0000);
        check("rst.busy", 32'(busy_o), 32'h00);
        check("rst.alu_ready", 32'(alu_ready), 32'd0);
        check("rst.mem_ready", 32'(mem_ready), 32'd0);
        check("rst.stall", 32'(stall_o), 32'd0);

        // ALU stream
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234;
        #1;
        check("alu0.alu_ready", 32'(alu_ready), 32'd1);
        check("alu0.mem_ready", 32'(mem_ready), 32'd1);
        tick();
        alu_rd = 3'd5; alu_data = 16'hBEEF;
        #1;
        check_wr("alu1", 1'b1, 3'd3, 16'h1234);
        check("alu1.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check_wr("alu2", 1'b1, 3'd5, 16'hBEEF);
        tick();
        check_wr("idle_hold", 1'b0, 3'd5, 16'hBEEF);

        // Memory path with scoreboard
        iss_valid = 1'b1; iss_rd = 3'd4;
        tick();
        iss_valid = 1'b0;
        check("iss4.busy", 32'(busy_o), 32'h10);
        mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'h00AA;
        tick();
        mem_valid = 1'b0;
        check("mem_e.wen", 32'(wen), 32'd0);
        check("mem_e.busy", 32'(busy_o), 32'h10);
        tick();
        check_wr("mem_e1", 1'b1, 3'd4, 16'h00AA);
        check("mem_e1.busy", 32'(busy_o), 32'h00);
        tick();
        check("mem_e2.wen", 32'(wen), 32'd0);

        // Full FIFO priority
        alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 16'h0777;
        mem_valid = 1'b1; mem_rd = 3'd1; mem_data = 16'h0001;
        tick();
        mem_rd = 3'd2; mem_data = 16'h0002;
        #1;
        check_wr("fill1", 1'b1, 3'd7, 16'h0777);
        check("fill1.mem_ready", 32'(mem_ready), 32'd1);
        check("fill1.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        mem_rd = 3'd3; mem_data = 16'h0333;
        #1;
        check("full.stall", 32'(stall_o), 32'd1);
        check("full.mem_ready", 32'(mem_ready), 32'd0);
        check("full.alu_ready", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        #1;
        check_wr("drain1", 1'b1, 3'd1, 16'h0001);
        check("drain1.stall", 32'(stall_o), 32'd0);
        check("drain1.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check_wr("alu_resume", 1'b1, 3'd7, 16'h0777);
        tick();
        check_wr("drain2", 1'b1, 3'd2, 16'h0002);
        tick();
        check("drain_done.wen", 32'(wen), 32'd0);

        // Simultaneous set/clear, and enqueue+dequeue at count 1
        iss_valid = 1'b1; iss_rd = 3'd6;
        mem_valid = 1'b1; mem_rd = 3'd6; mem_data = 16'h0066;
        tick();
        mem_rd = 3'd5; mem_data = 16'h0055;
        check("sim0.busy", 32'(busy_o), 32'h40);
        tick();
        iss_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_wr("sim1", 1'b1, 3'd6, 16'h0066);
        check("sim1.busy", 32'(busy_o), 32'h40);
        check("sim1.stall", 32'(stall_o), 32'd0);
        tick();
        check_wr("sim2", 1'b1, 3'd5, 16'h0055);
        check("sim2.busy", 32'(busy_o), 32'h40);
        tick();
        check("sim3.wen", 32'(wen), 32'd0);

        // rd = 0 handling
        alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'hFFFF;
        iss_valid = 1'b1; iss_rd = 3'd0;
        #1;
        check("rd0.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0; iss_valid = 1'b0;
        check_wr("rd0", 1'b0, 3'd0, 16'hFFFF);
        check("rd0.busy", 32'(busy_o), 32'h40);

        // Reset with two buffered entries
        alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h3333;
        mem_valid = 1'b1; mem_rd = 3'd1; mem_data = 16'h0AA1;
        iss_valid = 1'b1; iss_rd = 3'd1;
        tick();
        mem_rd = 3'd2; mem_data = 16'h0AA2;
        iss_valid = 1'b0;
        check("mid0.busy", 32'(busy_o), 32'h42);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check("mid1.stall", 32'(stall_o), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst.mem_ready", 32'(mem_ready), 32'd0);
        check("mid_rst.alu_ready", 32'(alu_ready), 32'd0);
        check("mid_rst.stall", 32'(stall_o), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check_wr("post_rst", 1'b0, 3'd0, 16'h0000);
        check("post_rst.busy", 32'(busy_o), 32'h00);
        check("post_rst.mem_ready", 32'(mem_ready), 32'd1);
        check("post_rst.stall", 32'(stall_o), 32'd0);
        tick();
        check_wr("no_stale1", 1'b0, 3'd0, 16'h0000);
        tick();
        check_wr("no_stale2", 1'b0, 3'd0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
